// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared types and encodings for the AES-128 round sequencer.
//             - controller state enumeration
//             - AddRoundKeys source-mux encodings
//             - number of rounds for AES-128
//             - 132-bit datapath word {tag[3:0], state[127:0]}
//  Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

   localparam int NUM_ROUNDS_128 = 10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEY   = 3'd1,
      S_ARK   = 3'd2,
      S_SUB   = 3'd3,
      S_SHIFT = 3'd4,
      S_MIX   = 3'd5,
      S_DONE  = 3'd6
   } aes_state_t;

   // AddRoundKeys input select; encoding 2'd1 is reserved
   localparam logic [1:0] SRC_IN = 2'd0;
   localparam logic [1:0] SRC_SR = 2'd2;
   localparam logic [1:0] SRC_MC = 2'd3;

   typedef struct packed {
      logic [3:0]   tag;
      logic [127:0] state;
   } aes_word_t;

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_ctrl
//  Purpose  : Sequencing FSM for the AES-128 encryption datapath. Steps one
//             block through the initial AddRoundKeys, rounds 1..NUM_ROUNDS-1
//             (Sub/Shift/Mix/ARK) and the final round (no MixColumns),
//             fetching each round key over a req/valid handshake.
//  Ports    : clk        system clock, rising edge
//             n_rst      asynchronous active-low reset
//             start      begin a block (sampled in IDLE only)
//             abort      cancel operation in progress
//             key_valid  requested round key is stable
//             key_req    round key request
//             key_round  index of requested round key
//             sub_en / shift_en / mix_en / ark_en  stage load enables
//             src_sel    AddRoundKeys input mux select
//             round      round tag for data bits [131:128]
//             busy       high in every state except IDLE
//             done       one-cycle pulse, ciphertext available
//  Revision : 1.0  initial release
// ============================================================================
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_128,
   parameter int ROUND_W    = 4
)(
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               abort,
   input  logic               key_valid,
   output logic               key_req,
   output logic [ROUND_W-1:0] key_round,
   output logic               sub_en,
   output logic               shift_en,
   output logic               mix_en,
   output logic               ark_en,
   output logic [1:0]         src_sel,
   output logic [ROUND_W-1:0] round,
   output logic               busy,
   output logic               done
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
   localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);

   aes_state_t         state;
   aes_state_t         next_state;
   logic [ROUND_W-1:0] round_cnt;
   logic [ROUND_W-1:0] round_nxt;

   // ------------------------------------------------------------------------
   // State and round counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_IDLE;
         round_cnt <= '0;
      end else begin
         state     <= next_state;
         round_cnt <= round_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      round_nxt  = round_cnt;
      key_req    = 1'b0;
      key_round  = '0;
      sub_en     = 1'b0;
      shift_en   = 1'b0;
      mix_en     = 1'b0;
      ark_en     = 1'b0;
      src_sel    = SRC_IN;
      busy       = 1'b1;
      done       = 1'b0;

      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            // start together with abort is treated as no request at all
            if (start && !abort) begin
               next_state = S_KEY;
            end
         end

         S_KEY: begin
            key_req   = 1'b1;
            key_round = round_cnt;
            if (key_valid) begin
               next_state = S_ARK;
            end
         end

         S_ARK: begin
            ark_en = 1'b1;
            if (round_cnt == '0) begin
               src_sel = SRC_IN;
            end else if (round_cnt == LAST_ROUND) begin
               src_sel = SRC_SR;
            end else begin
               src_sel = SRC_MC;
            end
            if (round_cnt == LAST_ROUND) begin
               next_state = S_DONE;
            end else begin
               // the round tag advances here so it stays constant from
               // SUB through the ARK of the new round
               next_state = S_SUB;
               round_nxt  = round_cnt + ROUND_ONE;
            end
         end

         S_SUB: begin
            sub_en     = 1'b1;
            next_state = S_SHIFT;
         end

         S_SHIFT: begin
            shift_en   = 1'b1;
            // the final round skips MixColumns and goes straight to its key
            next_state = (round_cnt == LAST_ROUND) ? S_KEY : S_MIX;
         end

         S_MIX: begin
            mix_en     = 1'b1;
            next_state = S_KEY;
         end

         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end

         default: begin
            next_state = S_IDLE;
         end
      endcase

      // abort wins over key_valid and over the DONE pulse's successor
      if (abort && (state != S_IDLE)) begin
         next_state = S_IDLE;
      end

      // every path back to IDLE clears the round tag
      if (next_state == S_IDLE) begin
         round_nxt = '0;
      end
   end

   assign round = round_cnt;

   // ------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------
   a_round_range : assert property (@(posedge clk) disable iff (!n_rst)
      round_cnt <= LAST_ROUND);

   a_enable_onehot : assert property (@(posedge clk) disable iff (!n_rst)
      $onehot0({sub_en, shift_en, mix_en, ark_en}));

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_ctrl
//  Purpose  : Self-checking bench for aes_round_ctrl. A behavioural schedule
//             model (list of operations per round, key waits expanded into
//             cycles) predicts every output cycle by cycle; an identity
//             datapath harness checks AddRoundKeys integration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_ctrl;
   import aes_pkg::*;

   localparam int NR = 10;
   localparam logic [127:0] KEY_DATA = 128'hFFEEDDCCBBAA99887766554433221100;
   localparam logic [127:0] IN_DATA  = 128'h00112233445566778899AABBCCDDEEFF;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_req;
   logic [3:0] key_round;
   logic       sub_en, shift_en, mix_en, ark_en;
   logic [1:0] src_sel;
   logic [3:0] round;
   logic       busy, done;

   always #5 clk = ~clk;

   aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(4)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .abort     (abort),
      .key_valid (key_valid),
      .key_req   (key_req),
      .key_round (key_round),
      .sub_en    (sub_en),
      .shift_en  (shift_en),
      .mix_en    (mix_en),
      .ark_en    (ark_en),
      .src_sel   (src_sel),
      .round     (round),
      .busy      (busy),
      .done      (done)
   );

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       key_req;
      logic [3:0] key_round;
      logic       sub;
      logic       shift;
      logic       mix;
      logic       ark;
      logic [1:0] src;
      logic [3:0] round;
   } obs_t;

   obs_t act;
   assign act = {busy, done, key_req, key_round, sub_en, shift_en, mix_en,
                 ark_en, src_sel, round};

   obs_t exp_q[$];
   int   waits[NR+1];
   int   tests = 0;
   int   fails = 0;

   // ---------------- identity datapath harness ----------------
   aes_word_t sub_q, shift_q, mix_q, ark_q;
   always_ff @(posedge clk) begin
      if (sub_en)   sub_q   <= ark_q;
      if (shift_en) shift_q <= sub_q;
      if (mix_en)   mix_q   <= shift_q;
      if (ark_en) begin
         ark_q.tag <= round;
         case (src_sel)
            2'd0:    ark_q.state <= IN_DATA ^ KEY_DATA;
            2'd2:    ark_q.state <= shift_q.state ^ KEY_DATA;
            default: ark_q.state <= mix_q.state ^ KEY_DATA;
         endcase
      end
   end

   // ---------------- reference schedule model ----------------
   function automatic obs_t mk(bit b, bit d, bit kr, int kround, bit s,
                               bit sh, bit m, bit a, int src, int rnd);
      obs_t o;
      o.busy = b; o.done = d; o.key_req = kr; o.key_round = 4'(kround);
      o.sub = s; o.shift = sh; o.mix = m; o.ark = a;
      o.src = 2'(src); o.round = 4'(rnd);
      return o;
   endfunction

   function automatic void push_key(int r);
      for (int i = 0; i <= waits[r]; i++)
         exp_q.push_back(mk(1, 0, 1, r, 0, 0, 0, 0, 0, r));
   endfunction

   function automatic void build_trace();
      exp_q.delete();
      push_key(0);
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int r = 1; r <= NR; r++) begin
         exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, r));
         exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, r));
         if (r < NR) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, r));
         push_key(r);
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, (r == NR) ? 2 : 3, r));
      end
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, NR));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endfunction

   function automatic int find_step(bit want_mix, int rnd);
      for (int i = 0; i < exp_q.size(); i++)
         if ((want_mix ? exp_q[i].mix : exp_q[i].shift) && exp_q[i].round == 4'(rnd))
            return i;
      return -1;
   endfunction

   function automatic int wait_sum();
      int s = 0;
      for (int r = 0; r <= NR; r++) s += waits[r];
      return s;
   endfunction

   // start_mode: 0 none, 1 random while busy, 2 pulses at cycles 5 and 30
   task automatic run_op(input string name, input int abort_at, input int rst_at,
                         input int start_mode, input bit chk_counts);
      int n, limit, kcnt, kr, done_cycle, done_cnt;
      int sub_c, shift_c, mix_c, ark_c;
      int ks[$];
      int ss[$];
      bit prev_kr, ok;
      kcnt = 0; done_cycle = -1; done_cnt = 0; prev_kr = 0;
      sub_c = 0; shift_c = 0; mix_c = 0; ark_c = 0;
      build_trace();
      limit = exp_q.size() - 2;
      if (abort_at >= 0) begin
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
         for (int j = 0; j < 3; j++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         limit = abort_at;
      end
      n = exp_q.size();
      @(negedge clk);
      start = 1'b1; abort = 1'b0; key_valid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tests++;
         if (act !== exp_q[i]) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h required %h", name, i + 1, act, exp_q[i]);
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = i + 1;
         end
         sub_c += int'(sub_en); shift_c += int'(shift_en);
         mix_c += int'(mix_en); ark_c += int'(ark_en);
         if (key_req === 1'b1 && !prev_kr) ks.push_back(int'(key_round));
         if (ark_en === 1'b1) ss.push_back(int'(src_sel));
         prev_kr = (key_req === 1'b1);
         if (i == rst_at) begin
            #1 n_rst = 1'b0;
            #1;
            tests++;
            if (act !== '0) begin
               fails++;
               $display("FAIL %s async_reset: got %h required 0", name, act);
            end
            start = 1'b0; abort = 1'b0; key_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            n_rst = 1'b1;
            return;
         end
         // stimulus for the next cycle
         if (key_req === 1'b1) begin
            kr = int'(key_round);
            if ($isunknown(key_round) || kr > NR) kr = NR;
            key_valid = (kcnt >= waits[kr]);
            kcnt++;
         end else begin
            kcnt = 0;
            key_valid = 1'($urandom_range(0, 1));
         end
         case (start_mode)
            1:       start = (i <= limit) ? 1'($urandom_range(0, 1)) : 1'b0;
            2:       start = (i + 1 == 5) || (i + 1 == 30);
            default: start = 1'b0;
         endcase
         abort = (i == abort_at);
      end
      start = 1'b0; abort = 1'b0;
      if (abort_at >= 0) begin
         tests++;
         if (done_cycle != -1) begin
            fails++;
            $display("FAIL %s done_after_abort: got cycle %0d required none", name, done_cycle);
         end
      end else begin
         tests++;
         if (done_cycle != 52 + wait_sum() || done_cnt != 1) begin
            fails++;
            $display("FAIL %s latency: got cycle %0d (pulses %0d) required %0d (1)",
                     name, done_cycle, done_cnt, 52 + wait_sum());
         end
      end
      if (chk_counts) begin
         tests++;
         if (sub_c != NR || shift_c != NR || mix_c != NR - 1 || ark_c != NR + 1) begin
            fails++;
            $display("FAIL %s pulse_counts: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     name, sub_c, shift_c, mix_c, ark_c, NR, NR, NR - 1, NR + 1);
         end
         ok = (ks.size() == NR + 1);
         for (int j = 0; j < ks.size() && ok; j++) ok = (ks[j] == j);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL %s key_order: got %0d handshakes required %0d in order 0..%0d",
                     name, ks.size(), NR + 1, NR);
         end
         ok = (ss.size() == NR + 1);
         for (int j = 0; j < ss.size() && ok; j++)
            ok = (ss[j] == ((j == 0) ? 0 : (j == NR) ? 2 : 3));
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL %s src_sel_seq: got %0d ARK cycles or wrong select, required 0,3x9,2",
                     name, ss.size());
         end
      end
   endtask

   function automatic void set_waits(int v);
      for (int r = 0; r <= NR; r++) waits[r] = v;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #12;
      tests++;
      if (act !== '0) begin
         fails++;
         $display("FAIL reset_hold: got %h required 0", act);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      tests++;
      if (act !== '0) begin
         fails++;
         $display("FAIL reset_release: got %h required 0", act);
      end
   endtask

   task automatic test_idle_abort();
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      tests++;
      if (act !== '0) begin
         fails++;
         $display("FAIL start_with_abort: got %h required 0", act);
      end
      start = 1'b0;
      @(negedge clk);
      tests++;
      if (act !== '0) begin
         fails++;
         $display("FAIL abort_in_idle: got %h required 0", act);
      end
      abort = 1'b0;
   endtask

   task automatic test_nominal();
      set_waits(0);
      run_op("nominal", -1, -1, 0, 1);
   endtask

   task automatic test_key_stall();
      set_waits(3);
      run_op("key_stall", -1, -1, 0, 1);
   endtask

   task automatic test_random_stall();
      for (int t = 0; t < 3; t++) begin
         for (int r = 0; r <= NR; r++) waits[r] = $urandom_range(0, 5);
         run_op("random_stall", -1, -1, 1, 1);
      end
   endtask

   task automatic test_start_while_busy();
      set_waits(0);
      run_op("start_busy", -1, -1, 2, 0);
   endtask

   task automatic test_abort();
      int idx;
      set_waits(0);
      build_trace();
      idx = find_step(1, 5);
      run_op("abort_mix5", idx, -1, 0, 0);
      run_op("after_abort", -1, -1, 0, 1);
      for (int r = 0; r <= NR; r++) waits[r] = $urandom_range(0, 2);
      build_trace();
      idx = $urandom_range(0, exp_q.size() - 2);
      run_op("abort_random", idx, -1, 1, 0);
   endtask

   task automatic test_async_reset();
      int idx;
      set_waits(0);
      build_trace();
      idx = find_step(0, 7);
      run_op("rst_shift7", -1, idx, 0, 0);
      run_op("after_reset", -1, -1, 0, 1);
   endtask

   task automatic test_integration();
      logic [127:0] fin;
      bit prev_ark, first_seen, done_seen;
      prev_ark = 0; first_seen = 0; done_seen = 0;
      fin = IN_DATA;
      for (int r = 0; r <= NR; r++) fin = fin ^ KEY_DATA;
      @(negedge clk);
      key_valid = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100 && !done_seen; c++) begin
         if (prev_ark && !first_seen) begin
            first_seen = 1;
            tests++;
            if (ark_q !== {4'h0, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF}) begin
               fails++;
               $display("FAIL integ_round0: got %h required 0FFFF..F", ark_q);
            end
         end
         if (done === 1'b1) begin
            done_seen = 1;
            tests++;
            if (ark_q !== {4'hA, fin}) begin
               fails++;
               $display("FAIL integ_done: got %h required %h", ark_q, {4'hA, fin});
            end
         end
         prev_ark = (ark_en === 1'b1);
         @(negedge clk);
      end
      tests++;
      if (!done_seen || !first_seen) begin
         fails++;
         $display("FAIL integ_timeout: got done=%0d ark0=%0d required 1/1", done_seen, first_seen);
      end
      key_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_idle_abort();
      test_nominal();
      test_key_stall();
      test_random_stall();
      test_start_while_busy();
      test_abort();
      test_async_reset();
      test_integration();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencing FSM for the AES-128 encryption datapath.
- Steps one 128-bit block through the initial AddRoundKeys, then rounds 1..9 (SubBytes, ShiftRows, MixColumns, AddRoundKeys), then round 10 (no MixColumns).
- Requests round keys from the key-expansion block over a req/valid handshake.
- Drives the 4-bit round tag carried in data bits [131:128].

Parameters:
- NUM_ROUNDS, 10, number of full rounds; the last round omits MixColumns.
- ROUND_W, 4, width of the round counter and round tag.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin encryption of the block on the input bus; sampled only in IDLE.
- abort  in  1  cancel the operation in progress.
- key_valid  in  1  round key for key_round is stable on the key bus.
- key_req  out  1  requesting the round key key_round.
- key_round  out  ROUND_W  index of the requested round key, 0..NUM_ROUNDS.
- sub_en  out  1  SubBytes stage load enable.
- shift_en  out  1  ShiftRows stage load enable.
- mix_en  out  1  MixColumns stage load enable.
- ark_en  out  1  AddRoundKeys enable.
- src_sel  out  2  AddRoundKeys input mux: 0 = input block, 2 = ShiftRows output, 3 = MixColumns output (1 is reserved).
- round  out  ROUND_W  round tag driven into data_in[131:128].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the AddRoundKeys output holds the ciphertext.

Behaviour:
- Reset values: all outputs 0; state IDLE; round counter 0.
- Stage enables are Moore outputs, one-hot; at most one of sub_en/shift_en/mix_en/ark_en is high per cycle.
- Each datapath stage is registered, so its result is valid the cycle after its enable.
- States: IDLE, KEY, ARK, SUB, SHIFT, MIX, DONE.
- IDLE: when start=1, go to KEY with round=0.
- KEY:
  - key_req=1, key_round=round.
  - Hold until key_valid=1 is sampled, then go to ARK.
  - key_valid is ignored in every other state.
  - The key-expansion block holds the key stable until its next key_req.
- ARK:
  - ark_en=1 for one cycle.
  - src_sel = 0 in round 0, 3 in rounds 1..NUM_ROUNDS-1, 2 in round NUM_ROUNDS.
  - Next state: DONE if round==NUM_ROUNDS; otherwise increment round and go to SUB.
- SUB: sub_en=1, one cycle, then go to SHIFT.
- SHIFT: shift_en=1, one cycle; go to KEY if round==NUM_ROUNDS, else MIX.
- MIX: mix_en=1, one cycle, then go to KEY.
- DONE: done=1 for one cycle, then IDLE. A start sampled in DONE is ignored.
- round stays constant across SUB..ARK of a round and is reset to 0 on entering IDLE.
- Latency with key_valid tied high:
  - 51 working states, then done is high in the cycle following the 52nd rising edge after the edge that samples start.
  - Each key wait cycle adds 1.
- start while busy: ignored; no re-arm, no effect on round.
- abort (any non-IDLE state): next state IDLE; all enables and done stay 0; key_req drops. abort has priority over key_valid and over DONE.
- abort in IDLE is ignored; start and abort high together in IDLE means stay in IDLE.
- Asynchronous reset mid-operation: immediate return to reset values. The datapath contents are don't-care afterwards.
- Round counter never wraps; values NUM_ROUNDS+1 and above are unreachable. Assertion: round <= NUM_ROUNDS.

Decomposition:
- Package aes_pkg holds:
  - the state enum type;
  - the src_sel encodings SRC_IN=2'd0, SRC_SR=2'd2, SRC_MC=2'd3;
  - NUM_ROUNDS_128=10;
  - the 132-bit data word typedef {tag[3:0], state[127:0]}.
- A single module; no sub-module needed. An optional key-handshake helper is not warranted.

Test Plan:
- Nominal run, key_valid tied 1, start pulsed once:
  - done rises 52 cycles after start.
  - 11 key_req handshakes with key_round 0..10 in order.
  - Pulse counts: sub_en 10, shift_en 10, mix_en 9, ark_en 11.
  - src_sel at each ark_en: 0, then 3 (x9), then 2.
- Key stall, key_valid asserted 3 cycles after each key_req rises:
  - done at cycle 52+33=85.
  - No enable asserted while key_req is high.
- start re-pulsed at cycles 5 and 30 of an active run: run unaffected; exactly one done pulse, at 52.
- abort at the MIX state of round 5:
  - Next cycle busy=0, round=0, key_req=0.
  - done never pulses.
  - A subsequent start completes normally in 52 cycles.
- n_rst dropped asynchronously mid-cycle during round 7 SHIFT:
  - All outputs 0 immediately, before the next edge.
  - After release, start gives a clean 52-cycle run.
- Integration with AddRoundKeys and stub stages (identity SubBytes/ShiftRows/MixColumns):
  - Key 'hFFEEDDCCBBAA99887766554433221100 for every round.
  - Input data 'h00112233445566778899AABBCCDDEEFF.
  - After the round-0 ARK, data_out = 'h0FFFF...F with tag 0.
  - At done, tag = 'hA.
